mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 14 +
 rtl/mux2_1.sv | 13 +
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 tb/tb_mem_access_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the SRAM access controller.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_CAP  = 3'd2,
    WR_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/mux2_1.sv
// N-bit two-input multiplexer: sel=0 passes a, sel=1 passes b.
module mux2_1 #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR front end and Moore sequencer for an asynchronous SRAM with fixed wait states.
//
// state   | meaning
// IDLE    | accepts LD_MAR/LD_MDR and a read or write request
// RD_WAIT | read strobes active, counting wait states
// RD_CAP  | read strobes active, MDR captures SRAM data at the closing edge
// WR_WAIT | write strobes active, counting wait states
// DONE    | one-cycle completion pulse, strobes released
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int N           = 16,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         LD_MAR,
  input  logic         LD_MDR,
  input  logic         Start_Rd,
  input  logic         Start_Wr,
  input  logic [N-1:0] Bus,
  input  logic [N-1:0] Data_from_SRAM,
  output logic [N-1:0] MAR,
  output logic [N-1:0] MDR,
  output logic [N-1:0] Data_to_SRAM,
  output logic         CE_N,
  output logic         OE_N,
  output logic         WE_N,
  output logic         Busy,
  output logic         Done
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [N-1:0] mdr_in;

  // MDR takes Bus in IDLE and SRAM data only in the capture state.
  mux2_1 #(.N(N)) u_mdr_mux (
    .a   (Bus),
    .b   (Data_from_SRAM),
    .sel (state == RD_CAP),
    .y   (mdr_in)
  );

  assign Data_to_SRAM = MDR;

  // Strobes, Busy and Done are registered alongside the state so they follow it exactly.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      MAR   <= '0;
      MDR   <= '0;
      cnt   <= '0;
      CE_N  <= 1'b1;
      OE_N  <= 1'b1;
      WE_N  <= 1'b1;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LD_MAR) MAR <= Bus;
          if (LD_MDR) MDR <= mdr_in;
          if (Start_Rd) begin
            state <= RD_WAIT;
            cnt   <= CNT_LOAD;
            CE_N  <= 1'b0;
            OE_N  <= 1'b0;
            Busy  <= 1'b1;
          end else if (Start_Wr) begin
            state <= WR_WAIT;
            cnt   <= CNT_LOAD;
            CE_N  <= 1'b0;
            WE_N  <= 1'b0;
            Busy  <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt == 4'd0) state <= RD_CAP;
          else             cnt   <= cnt - 4'd1;
        end
        RD_CAP: begin
          MDR   <= mdr_in;
          state <= DONE;
          CE_N  <= 1'b1;
          OE_N  <= 1'b1;
          Done  <= 1'b1;
        end
        WR_WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            CE_N  <= 1'b1;
            WE_N  <= 1'b1;
            Done  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          CE_N  <= 1'b1;
          OE_N  <= 1'b1;
          WE_N  <= 1'b1;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of single accesses plus reset-abort and back-to-back sequences.
module tb_mem_access_ctrl;

  localparam int N = 16;
  localparam int W = 2;

  logic         Clk = 1'b0;
  logic         Reset, LD_MAR, LD_MDR, Start_Rd, Start_Wr;
  logic [N-1:0] Bus, Data_from_SRAM;
  logic [N-1:0] MAR, MDR, Data_to_SRAM;
  logic         CE_N, OE_N, WE_N, Busy, Done;

  mem_access_ctrl #(.N(N), .WAIT_CYCLES(W)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .LD_MAR         (LD_MAR),
    .LD_MDR         (LD_MDR),
    .Start_Rd       (Start_Rd),
    .Start_Wr       (Start_Wr),
    .Bus            (Bus),
    .Data_from_SRAM (Data_from_SRAM),
    .MAR            (MAR),
    .MDR            (MDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .CE_N           (CE_N),
    .OE_N           (OE_N),
    .WE_N           (WE_N),
    .Busy           (Busy),
    .Done           (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic         ld_mdr;
    logic         distract;
    logic [N-1:0] addr;
    logic [N-1:0] bus;
    logic [N-1:0] sram;
    int           exp_done;
    int           exp_oe;
    int           exp_we;
  } vec_t;

  vec_t         vecs[6];
  logic [N-1:0] sb_q[$];
  logic [N-1:0] mdr_model;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    LD_MAR = 1'b0; LD_MDR = 1'b0; Start_Rd = 1'b0; Start_Wr = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int           oe_cnt = 0, we_cnt = 0, dones = 0, done_at = -1;
    logic         overlap = 1'b0, mar_moved = 1'b0, d2s_bad = 1'b0, busy_bad = 1'b0;
    logic [N-1:0] exp_mdr;
    @(negedge Clk);
    LD_MAR = 1'b1; Bus = v.addr;
    @(negedge Clk);
    LD_MAR = 1'b0; LD_MDR = v.ld_mdr; Bus = v.bus;
    Start_Rd = v.rd; Start_Wr = v.wr; Data_from_SRAM = v.sram;
    if (v.rd) mdr_model = v.sram;
    else if (v.ld_mdr) mdr_model = v.bus;
    sb_q.push_back(mdr_model);
    exp_mdr = mdr_model;
    for (int c = 1; c <= 16; c++) begin
      @(negedge Clk);
      if (!OE_N) oe_cnt++;
      if (!WE_N) begin
        we_cnt++;
        if (Data_to_SRAM !== exp_mdr) d2s_bad = 1'b1;
      end
      if (!OE_N && !WE_N) overlap = 1'b1;
      if (MAR !== v.addr) mar_moved = 1'b1;
      if (c == 1 && !Busy) busy_bad = 1'b1;
      if (done_at > 0 && c == done_at + 1 && Busy) busy_bad = 1'b1;
      if (Done) begin
        dones++;
        if (done_at < 0) begin
          done_at = c;
          check($sformatf("v%0d mdr_at_done", idx), MDR, sb_q.pop_front());
        end
      end
      if (c == 1 && v.distract) begin
        LD_MAR = 1'b1; LD_MDR = 1'b1; Bus = 16'hFFFF; Start_Rd = 1'b1; Start_Wr = 1'b1;
      end else begin
        idle_inputs();
      end
    end
    if (done_at < 0) begin
      check($sformatf("v%0d done_timeout", idx), 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      check($sformatf("v%0d done_cycle", idx), done_at, v.exp_done);
    end
    check($sformatf("v%0d oe_low_cycles", idx), oe_cnt, v.exp_oe);
    check($sformatf("v%0d we_low_cycles", idx), we_cnt, v.exp_we);
    check($sformatf("v%0d done_count", idx), dones, 1);
    check($sformatf("v%0d oe_we_overlap", idx), overlap, 0);
    check($sformatf("v%0d mar_stable", idx), mar_moved, 0);
    check($sformatf("v%0d data_to_sram", idx), d2s_bad, 0);
    check($sformatf("v%0d busy_window", idx), busy_bad, 0);
  endtask

  initial begin
    int done_c[$];
    int oe_start[$];
    logic prev_oe;
    logic seen_done;

    //         rd    wr    ldmdr dist  addr      bus       sram      done   oe     we
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, W + 2, W + 1, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, W + 1, 0,     W};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h5555, 16'hA5A5, W + 2, W + 1, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h4321, 16'h0000, 16'h0F0F, W + 2, W + 1, 0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, W + 1, 0,     W};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, W + 2, W + 1, 0};

    Reset = 1'b1; idle_inputs(); Bus = '0; Data_from_SRAM = '0;
    mdr_model = '0;
    repeat (2) @(negedge Clk);
    check("rst_mar", MAR, 0);
    check("rst_mdr", MDR, 0);
    check("rst_strobes", {CE_N, OE_N, WE_N}, 3'b111);
    check("rst_busy_done", {Busy, Done}, 2'b00);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a read wait state.
    @(negedge Clk);
    LD_MAR = 1'b1; Bus = 16'h0100;
    @(negedge Clk);
    LD_MAR = 1'b0; Start_Rd = 1'b1; Data_from_SRAM = 16'hCAFE;
    @(negedge Clk);
    Start_Rd = 1'b0;
    check("abort_in_rd_wait", {Busy, OE_N}, 2'b10);
    #2 Reset = 1'b1;
    #1;
    check("abort_strobes_async", {CE_N, OE_N, WE_N}, 3'b111);
    check("abort_busy_async", Busy, 0);
    @(negedge Clk);
    Reset = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (Done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_mdr", MDR, 0);
    check("abort_mar", MAR, 0);
    mdr_model = '0;

    // Start_Rd held high: one IDLE cycle between each Done and the next read.
    @(negedge Clk);
    Start_Rd = 1'b1; Data_from_SRAM = 16'h1111;
    prev_oe = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (prev_oe && !OE_N) oe_start.push_back(c);
      prev_oe = OE_N;
      if (Done) begin
        done_c.push_back(c);
        check($sformatf("b2b_mdr_c%0d", c), MDR, 16'h1111);
      end
      if (c == 20) Start_Rd = 1'b0;
    end
    check("b2b_done_count", done_c.size(), 4);
    check("b2b_oe_start_count", oe_start.size(), 4);
    for (int k = 0; k + 1 < done_c.size() && k + 1 < oe_start.size(); k++)
      check($sformatf("b2b_gap_%0d", k), oe_start[k + 1], done_c[k] + 2);
    repeat (3) @(negedge Clk);
    check("b2b_idle_after", {Busy, OE_N}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
